// File: rtl/calc_controller.sv
// Calculator keypad/operation sequencer: builds BCD operands, issues ALU requests, drives display value.
// Optional repeated-equals support is compiled in with CALC_REPEAT_EQ_EN.

package calc_pkg;
  localparam int NumDigits = 8;
  localparam int SigW      = 4 * NumDigits;

  typedef struct packed {
    logic            sign;
    logic            error;
    logic [2:0]      exponent;
    logic [SigW-1:0] significand;
  } num_t;

  typedef enum logic [2:0] {
    OP_NONE = 3'd0,
    OP_ADD  = 3'd1,
    OP_SUB  = 3'd2,
    OP_MUL  = 3'd3,
    OP_DIV  = 3'd4
  } op_t;

  typedef enum logic [4:0] {
    B_NONE       = 5'd0,
    B_0          = 5'd1,
    B_1          = 5'd2,
    B_2          = 5'd3,
    B_3          = 5'd4,
    B_4          = 5'd5,
    B_5          = 5'd6,
    B_6          = 5'd7,
    B_7          = 5'd8,
    B_8          = 5'd9,
    B_9          = 5'd10,
    B_DOT        = 5'd11,
    B_OP_ADD     = 5'd12,
    B_OP_SUB     = 5'd13,
    B_OP_MUL     = 5'd14,
    B_OP_DIV     = 5'd15,
    B_OP_EQ      = 5'd16,
    B_CLEAR      = 5'd17,
    B_MEM_ADD    = 5'd18,
    B_MEM_SUB    = 5'd19,
    B_MEM_RECALL = 5'd20,
    B_MEM_CLEAR  = 5'd21,
    B_SQRT       = 5'd22,
    B_PERCENT    = 5'd23,
    B_UNKNOWN    = 5'd31
  } active_button_t;
endpackage

module calc_controller #(
  parameter int NumDigits = calc_pkg::NumDigits
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     button_valid_i,
  input  calc_pkg::active_button_t button_i,
  output logic                     alu_req_valid_o,
  input  logic                     alu_req_ready_i,
  output calc_pkg::num_t           alu_a_o,
  output calc_pkg::num_t           alu_b_o,
  output calc_pkg::op_t            alu_op_o,
  input  logic                     alu_rsp_valid_i,
  input  calc_pkg::num_t           alu_rsp_i,
  output calc_pkg::num_t           display_o,
  output logic                     busy_o
);
  import calc_pkg::*;

  localparam int              CntW     = $clog2(NumDigits + 1);
  localparam logic [CntW-1:0] MaxCount = CntW'(NumDigits);
  localparam logic [2:0]      MaxExp   = 3'(NumDigits - 1);

  typedef enum logic [2:0] {
    S_ENTRY_A, S_OP_WAIT, S_ENTRY_B, S_REQ, S_RSP, S_RESULT, S_ERROR
  } state_t;

  function automatic op_t button2op(active_button_t b);
    case (b)
      B_OP_ADD: return OP_ADD;
      B_OP_SUB: return OP_SUB;
      B_OP_MUL: return OP_MUL;
      B_OP_DIV: return OP_DIV;
      default:  return OP_NONE;
    endcase
  endfunction

  state_t          r_state, w_nextState;
  num_t            r_entry, w_nextEntry, r_a, w_nextA, r_b, w_nextB;
  num_t            r_result, w_nextResult, r_display, w_nextDisplay;
  num_t            w_baseEntry, w_keyEntry;
  logic [CntW-1:0] r_count, w_nextCount, w_baseCount, w_keyCount;
  logic            r_dot, w_nextDot, w_baseDot, w_keyDot;
  op_t             r_op, w_nextOp, r_pendingOp, w_nextPendingOp;
  logic            r_clearPending, w_nextClearPending;
  logic            w_doReset, w_isDigit, w_isOp;
  logic [3:0]      w_digit;
`ifdef CALC_REPEAT_EQ_EN
  num_t            r_lastB, w_nextLastB;
  op_t             r_lastOp, w_nextLastOp;
`endif

  always_comb begin
    w_nextState        = r_state;
    w_nextEntry        = r_entry;
    w_nextCount        = r_count;
    w_nextDot          = r_dot;
    w_nextA            = r_a;
    w_nextB            = r_b;
    w_nextOp           = r_op;
    w_nextPendingOp    = r_pendingOp;
    w_nextResult       = r_result;
    w_nextClearPending = r_clearPending;
    w_nextDisplay      = r_display;
`ifdef CALC_REPEAT_EQ_EN
    w_nextLastB        = r_lastB;
    w_nextLastOp       = r_lastOp;
`endif
    w_doReset = 1'b0;
    w_isDigit = button_i inside {[B_0:B_9]};
    w_digit   = 4'(button_i - B_0);
    w_isOp    = (button2op(button_i) != OP_NONE);

    // A keypress after an operator or a finished result starts a fresh operand.
    w_baseEntry = r_entry;
    w_baseCount = r_count;
    w_baseDot   = r_dot;
    if (r_state == S_OP_WAIT || r_state == S_RESULT) begin
      w_baseEntry = '0;
      w_baseCount = '0;
      w_baseDot   = 1'b0;
    end
    w_keyEntry = w_baseEntry;
    w_keyCount = w_baseCount;
    w_keyDot   = w_baseDot;
    if (w_isDigit) begin
      if (!(w_digit == 4'd0 && w_baseEntry.significand == '0 && !w_baseDot) &&
          w_baseCount != MaxCount && !(w_baseDot && w_baseEntry.exponent == MaxExp)) begin
        w_keyEntry.significand = {w_baseEntry.significand[SigW-5:0], w_digit};
        w_keyCount             = w_baseCount + CntW'(1);
        if (w_baseDot) w_keyEntry.exponent = w_baseEntry.exponent + 3'd1;
      end
    end else if (button_i == B_DOT) begin
      w_keyDot = 1'b1;
    end

    case (r_state)
      S_ENTRY_A, S_OP_WAIT, S_ENTRY_B, S_RESULT: begin
        if (button_valid_i) begin
          if (button_i == B_CLEAR) begin
            w_doReset = 1'b1;
          end else if (w_isDigit || button_i == B_DOT) begin
            w_nextEntry = w_keyEntry;
            w_nextCount = w_keyCount;
            w_nextDot   = w_keyDot;
            w_nextState = (r_state == S_ENTRY_A || r_state == S_RESULT) ? S_ENTRY_A : S_ENTRY_B;
          end else if (w_isOp) begin
            case (r_state)
              S_ENTRY_A: begin
                w_nextA     = r_entry;
                w_nextOp    = button2op(button_i);
                w_nextState = S_OP_WAIT;
              end
              S_OP_WAIT: w_nextOp = button2op(button_i);
              S_RESULT: begin
                w_nextA     = r_result;
                w_nextOp    = button2op(button_i);
                w_nextState = S_OP_WAIT;
              end
              default: begin
                w_nextB         = r_entry;
                w_nextPendingOp = button2op(button_i);
                w_nextState     = S_REQ;
`ifdef CALC_REPEAT_EQ_EN
                w_nextLastB     = r_entry;
                w_nextLastOp    = r_op;
`endif
              end
            endcase
          end else if (button_i == B_OP_EQ) begin
            if (r_state == S_ENTRY_B) begin
              w_nextB         = r_entry;
              w_nextPendingOp = OP_NONE;
              w_nextState     = S_REQ;
`ifdef CALC_REPEAT_EQ_EN
              w_nextLastB     = r_entry;
              w_nextLastOp    = r_op;
            end else if (r_state == S_RESULT) begin
              w_nextA         = r_result;
              w_nextB         = r_lastB;
              w_nextOp        = r_lastOp;
              w_nextPendingOp = OP_NONE;
              w_nextState     = S_REQ;
`endif
            end
          end
        end
      end
      S_REQ: begin
        if (button_valid_i && button_i == B_CLEAR) w_nextClearPending = 1'b1;
        if (alu_req_ready_i) w_nextState = S_RSP;
      end
      S_RSP: begin
        // A clear during the transaction only takes effect once the response is consumed.
        w_nextClearPending = r_clearPending | (button_valid_i && button_i == B_CLEAR);
        if (alu_rsp_valid_i) begin
          if (w_nextClearPending) begin
            w_doReset = 1'b1;
          end else if (alu_rsp_i.error) begin
            w_nextResult       = alu_rsp_i;
            w_nextResult.error = 1'b1;
            w_nextState        = S_ERROR;
          end else if (r_pendingOp != OP_NONE) begin
            w_nextA     = alu_rsp_i;
            w_nextOp    = r_pendingOp;
            w_nextState = S_OP_WAIT;
          end else begin
            w_nextResult = alu_rsp_i;
            w_nextState  = S_RESULT;
          end
        end
      end
      S_ERROR: if (button_valid_i && button_i == B_CLEAR) w_doReset = 1'b1;
      default: w_nextState = S_ENTRY_A;
    endcase

    if (w_doReset) begin
      w_nextState        = S_ENTRY_A;
      w_nextEntry        = '0;
      w_nextCount        = '0;
      w_nextDot          = 1'b0;
      w_nextA            = '0;
      w_nextB            = '0;
      w_nextOp           = OP_NONE;
      w_nextPendingOp    = OP_NONE;
      w_nextResult       = '0;
      w_nextClearPending = 1'b0;
`ifdef CALC_REPEAT_EQ_EN
      w_nextLastB        = '0;
      w_nextLastOp       = OP_NONE;
`endif
    end

    case (w_nextState)
      S_ENTRY_A, S_ENTRY_B: w_nextDisplay = w_nextEntry;
      S_OP_WAIT:            w_nextDisplay = w_nextA;
      S_RESULT, S_ERROR:    w_nextDisplay = w_nextResult;
      default:              w_nextDisplay = r_display;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state        <= S_ENTRY_A;
      r_entry        <= '0;
      r_count        <= '0;
      r_dot          <= 1'b0;
      r_a            <= '0;
      r_b            <= '0;
      r_op           <= OP_NONE;
      r_pendingOp    <= OP_NONE;
      r_result       <= '0;
      r_clearPending <= 1'b0;
      r_display      <= '0;
`ifdef CALC_REPEAT_EQ_EN
      r_lastB        <= '0;
      r_lastOp       <= OP_NONE;
`endif
    end else begin
      r_state        <= w_nextState;
      r_entry        <= w_nextEntry;
      r_count        <= w_nextCount;
      r_dot          <= w_nextDot;
      r_a            <= w_nextA;
      r_b            <= w_nextB;
      r_op           <= w_nextOp;
      r_pendingOp    <= w_nextPendingOp;
      r_result       <= w_nextResult;
      r_clearPending <= w_nextClearPending;
      r_display      <= w_nextDisplay;
`ifdef CALC_REPEAT_EQ_EN
      r_lastB        <= w_nextLastB;
      r_lastOp       <= w_nextLastOp;
`endif
    end
  end

  assign alu_req_valid_o = (r_state == S_REQ);
  assign busy_o          = (r_state == S_REQ) || (r_state == S_RSP);
  assign alu_a_o         = r_a;
  assign alu_b_o         = r_b;
  assign alu_op_o        = r_op;
  assign display_o       = r_display;

endmodule

// File: tb/tb_calc_controller.sv
// Self-checking bench for calc_controller: keypad vector table plus ALU scoreboard sequences.
// Define CALC_REPEAT_EQ_EN for both files to exercise repeated equals.

module tb_calc_controller;
  import calc_pkg::*;

  logic           clk_i = 1'b0;
  logic           rst_ni = 1'b1;
  logic           button_valid_i = 1'b0;
  active_button_t button_i = B_NONE;
  logic           alu_req_ready_i = 1'b1;
  logic           alu_rsp_valid_i = 1'b0;
  num_t           alu_rsp_i = '0;
  logic           alu_req_valid_o, busy_o;
  num_t           alu_a_o, alu_b_o, display_o;
  op_t            alu_op_o;

  int   errors = 0;
  int   checks = 0;
  int   validCycles = 0;
  int   rspCountdown = 0;
  int   rspDelay = 2;
  num_t rspPending = '0;

  typedef struct {
    num_t a;
    num_t b;
    op_t  op;
    num_t rsp;
  } txn_t;
  txn_t sbq[$];

  typedef struct {
    active_button_t btn;
    logic [31:0]    sig;
    logic [2:0]     exp;
  } vec_t;
  vec_t vecs[$];

  calc_controller #(.NumDigits(8)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .button_valid_i(button_valid_i), .button_i(button_i),
    .alu_req_valid_o(alu_req_valid_o), .alu_req_ready_i(alu_req_ready_i),
    .alu_a_o(alu_a_o), .alu_b_o(alu_b_o), .alu_op_o(alu_op_o),
    .alu_rsp_valid_i(alu_rsp_valid_i), .alu_rsp_i(alu_rsp_i),
    .display_o(display_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic num_t mkNum(logic [31:0] sig, logic [2:0] exp, logic err);
    num_t n;
    n = '0;
    n.error = err;
    n.exponent = exp;
    n.significand = sig;
    return n;
  endfunction

  task automatic checkOutput(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Called at a falling edge; returns at the next falling edge after the press was sampled.
  task automatic applyStimulus(active_button_t b);
    button_valid_i = 1'b1;
    button_i = b;
    @(negedge clk_i);
    button_valid_i = 1'b0;
    button_i = B_NONE;
  endtask

  task automatic waitIdle(string name);
    bit done = 1'b0;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk_i);
      if (!busy_o) done = 1'b1;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("[TB] FAIL %s: busy_o still 1 after 50 cycles, required 0", name);
    end
  endtask

  // ALU model: checks each accepted request against the scoreboard and returns its response later.
  always begin
    @(negedge clk_i);
    #1;
    alu_rsp_valid_i = 1'b0;
    if (rspCountdown > 0) begin
      rspCountdown--;
      if (rspCountdown == 0) begin
        alu_rsp_valid_i = 1'b1;
        alu_rsp_i = rspPending;
      end
    end
    if (alu_req_valid_o) validCycles++;
    if (alu_req_valid_o && alu_req_ready_i) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_req: got op=%0d a=%0h b=%0h, required no request",
                 alu_op_o, alu_a_o, alu_b_o);
      end else begin
        txn_t t;
        t = sbq.pop_front();
        checkOutput("req_a", alu_a_o, t.a);
        checkOutput("req_b", alu_b_o, t.b);
        checkOutput("req_op", alu_op_o, t.op);
        rspPending = t.rsp;
        rspCountdown = rspDelay;
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs.push_back('{B_CLEAR, 32'h0, 3'd0});
    vecs.push_back('{B_1, 32'h1, 3'd0});
    vecs.push_back('{B_2, 32'h12, 3'd0});
    vecs.push_back('{B_DOT, 32'h12, 3'd0});
    vecs.push_back('{B_5, 32'h125, 3'd1});
    vecs.push_back('{B_CLEAR, 32'h0, 3'd0});
    vecs.push_back('{B_0, 32'h0, 3'd0});
    vecs.push_back('{B_0, 32'h0, 3'd0});
    vecs.push_back('{B_7, 32'h7, 3'd0});
    vecs.push_back('{B_1, 32'h71, 3'd0});
    vecs.push_back('{B_2, 32'h712, 3'd0});
    vecs.push_back('{B_3, 32'h7123, 3'd0});
    vecs.push_back('{B_4, 32'h71234, 3'd0});
    vecs.push_back('{B_5, 32'h712345, 3'd0});
    vecs.push_back('{B_6, 32'h7123456, 3'd0});
    vecs.push_back('{B_8, 32'h71234568, 3'd0});
    vecs.push_back('{B_9, 32'h71234568, 3'd0});
    vecs.push_back('{B_SQRT, 32'h71234568, 3'd0});
    vecs.push_back('{B_CLEAR, 32'h0, 3'd0});
    vecs.push_back('{B_DOT, 32'h0, 3'd0});
    vecs.push_back('{B_3, 32'h3, 3'd1});
    vecs.push_back('{B_DOT, 32'h3, 3'd1});
    vecs.push_back('{B_4, 32'h34, 3'd2});
    vecs.push_back('{B_OP_EQ, 32'h34, 3'd2});
    vecs.push_back('{B_CLEAR, 32'h0, 3'd0});
    vecs.push_back('{B_DOT, 32'h0, 3'd0});
    vecs.push_back('{B_1, 32'h1, 3'd1});
    vecs.push_back('{B_2, 32'h12, 3'd2});
    vecs.push_back('{B_3, 32'h123, 3'd3});
    vecs.push_back('{B_4, 32'h1234, 3'd4});
    vecs.push_back('{B_5, 32'h12345, 3'd5});
    vecs.push_back('{B_6, 32'h123456, 3'd6});
    vecs.push_back('{B_7, 32'h1234567, 3'd7});
    vecs.push_back('{B_8, 32'h1234567, 3'd7});
    vecs.push_back('{B_CLEAR, 32'h0, 3'd0});

    #1 rst_ni = 1'b0;
    #2;
    checkOutput("reset_display", display_o, mkNum(32'h0, 3'd0, 1'b0));
    checkOutput("reset_valid", alu_req_valid_o, 1'b0);
    checkOutput("reset_busy", busy_o, 1'b0);
    checkOutput("reset_op", alu_op_o, OP_NONE);
    checkOutput("reset_ab", {alu_a_o, alu_b_o}, 74'h0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].btn);
      checkOutput($sformatf("vec%0d", i), {busy_o, display_o},
                  {1'b0, mkNum(vecs[i].sig, vecs[i].exp, 1'b0)});
    end

    // Simple expression: 12 + 3 = 15 with ready high.
    sbq.push_back('{mkNum(32'h12, 3'd0, 1'b0), mkNum(32'h3, 3'd0, 1'b0), OP_ADD,
                    mkNum(32'h15, 3'd0, 1'b0)});
    applyStimulus(B_1);
    applyStimulus(B_2);
    applyStimulus(B_OP_ADD);
    checkOutput("opwait_display", display_o, mkNum(32'h12, 3'd0, 1'b0));
    applyStimulus(B_3);
    validCycles = 0;
    applyStimulus(B_OP_EQ);
    waitIdle("add_idle");
    checkOutput("add_valid_cycles", validCycles, 1);
    checkOutput("add_display", display_o, mkNum(32'h15, 3'd0, 1'b0));

    // Chained: 2 * 3 - 1 = 5.
    applyStimulus(B_CLEAR);
    sbq.push_back('{mkNum(32'h2, 3'd0, 1'b0), mkNum(32'h3, 3'd0, 1'b0), OP_MUL,
                    mkNum(32'h6, 3'd0, 1'b0)});
    sbq.push_back('{mkNum(32'h6, 3'd0, 1'b0), mkNum(32'h1, 3'd0, 1'b0), OP_SUB,
                    mkNum(32'h5, 3'd0, 1'b0)});
    applyStimulus(B_2);
    applyStimulus(B_OP_MUL);
    applyStimulus(B_3);
    applyStimulus(B_OP_SUB);
    waitIdle("chain_idle1");
    checkOutput("chain_display1", display_o, mkNum(32'h6, 3'd0, 1'b0));
    checkOutput("chain_op", alu_op_o, OP_SUB);
    applyStimulus(B_1);
    applyStimulus(B_OP_EQ);
    waitIdle("chain_idle2");
    checkOutput("chain_display2", display_o, mkNum(32'h5, 3'd0, 1'b0));

    // Stalled request with a clear pressed while waiting for ready.
    applyStimulus(B_CLEAR);
    alu_req_ready_i = 1'b0;
    sbq.push_back('{mkNum(32'h4, 3'd0, 1'b0), mkNum(32'h5, 3'd0, 1'b0), OP_ADD,
                    mkNum(32'h9, 3'd0, 1'b0)});
    applyStimulus(B_4);
    applyStimulus(B_OP_ADD);
    applyStimulus(B_5);
    applyStimulus(B_OP_EQ);
    for (int i = 0; i < 5; i++) begin
      checkOutput($sformatf("stall_valid%0d", i), alu_req_valid_o, 1'b1);
      checkOutput($sformatf("stall_a%0d", i), alu_a_o, mkNum(32'h4, 3'd0, 1'b0));
      checkOutput($sformatf("stall_b%0d", i), alu_b_o, mkNum(32'h5, 3'd0, 1'b0));
      checkOutput($sformatf("stall_op%0d", i), alu_op_o, OP_ADD);
      button_valid_i = (i == 2);
      button_i = (i == 2) ? B_CLEAR : B_NONE;
      @(negedge clk_i);
    end
    button_valid_i = 1'b0;
    button_i = B_NONE;
    alu_req_ready_i = 1'b1;
    waitIdle("stall_idle");
    checkOutput("stall_discard", {busy_o, display_o}, {1'b0, mkNum(32'h0, 3'd0, 1'b0)});
    checkOutput("stall_op_reset", alu_op_o, OP_NONE);
    applyStimulus(B_3);
    checkOutput("stall_entry", display_o, mkNum(32'h3, 3'd0, 1'b0));

    // ALU error: 9 / 0 reports an error, only clear leaves it.
    applyStimulus(B_CLEAR);
    sbq.push_back('{mkNum(32'h9, 3'd0, 1'b0), mkNum(32'h0, 3'd0, 1'b0), OP_DIV,
                    mkNum(32'h0, 3'd0, 1'b1)});
    applyStimulus(B_9);
    applyStimulus(B_OP_DIV);
    applyStimulus(B_0);
    applyStimulus(B_OP_EQ);
    waitIdle("err_idle");
    checkOutput("err_display", display_o, mkNum(32'h0, 3'd0, 1'b1));
    applyStimulus(B_5);
    checkOutput("err_digit", display_o, mkNum(32'h0, 3'd0, 1'b1));
    applyStimulus(B_OP_ADD);
    checkOutput("err_op", display_o, mkNum(32'h0, 3'd0, 1'b1));
    applyStimulus(B_CLEAR);
    checkOutput("err_clear", display_o, mkNum(32'h0, 3'd0, 1'b0));

    // A press without its strobe must not register.
    button_i = B_7;
    @(negedge clk_i);
    button_i = B_NONE;
    checkOutput("no_strobe", display_o, mkNum(32'h0, 3'd0, 1'b0));

    // Equals pressed twice after 5 + 2.
    sbq.push_back('{mkNum(32'h5, 3'd0, 1'b0), mkNum(32'h2, 3'd0, 1'b0), OP_ADD,
                    mkNum(32'h7, 3'd0, 1'b0)});
    applyStimulus(B_5);
    applyStimulus(B_OP_ADD);
    applyStimulus(B_2);
    applyStimulus(B_OP_EQ);
    waitIdle("rep_idle1");
    checkOutput("rep_display1", display_o, mkNum(32'h7, 3'd0, 1'b0));
`ifdef CALC_REPEAT_EQ_EN
    sbq.push_back('{mkNum(32'h7, 3'd0, 1'b0), mkNum(32'h2, 3'd0, 1'b0), OP_ADD,
                    mkNum(32'h9, 3'd0, 1'b0)});
    applyStimulus(B_OP_EQ);
    waitIdle("rep_idle2");
    checkOutput("rep_display2", display_o, mkNum(32'h9, 3'd0, 1'b0));
`else
    applyStimulus(B_OP_EQ);
    checkOutput("rep_ignored", {busy_o, display_o}, {1'b0, mkNum(32'h7, 3'd0, 1'b0)});
    repeat (4) @(negedge clk_i);
`endif

    checkOutput("sb_empty", sbq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
